// File: rtl/decim_pkg.sv
// Shared definitions for the boxcar decimator: FIFO data width and the
// Avalon write-side FSM state type.
package decim_pkg;

    localparam int unsigned FIFO_DW = 32;

    typedef enum logic [0:0] {
        IDLE,
        WRITE
    } wr_state_e;

endpackage

// File: rtl/decim_accum.sv
// Boxcar accumulator and sample counter. Sums N = 2**DECIM_LOG2 accepted
// samples and emits the floored mean together with a one-cycle result_valid_o
// on the edge that accepts the last sample of the group.
module decim_accum
    import decim_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DECIM_LOG2 = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     in_valid_i,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic signed [DATA_W-1:0] result_o,
    output logic                     result_valid_o
);

    localparam int unsigned AccW = DATA_W + DECIM_LOG2;

    logic signed [AccW-1:0]  acc_q, acc_d;
    logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
    logic signed [AccW-1:0]  sum;
    logic                    take;
    logic                    last;

    // Next-state for accumulator/counter plus the combinational result.
    always_comb begin
        take  = enable_i & in_valid_i;
        last  = take && (cnt_q == {DECIM_LOG2{1'b1}});
        sum   = acc_q + {{DECIM_LOG2{in_data_i[DATA_W-1]}}, in_data_i};
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (!enable_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take) begin
            // Counter is exactly DECIM_LOG2 bits wide, so N-1 wraps to 0.
            cnt_d = cnt_q + 1'b1;
            acc_d = last ? '0 : sum;
        end
        // Dropping the low DECIM_LOG2 bits of a signed sum is an arithmetic
        // right shift (floor); the remaining DATA_W bits always hold the mean.
        result_o       = sum[AccW-1:DECIM_LOG2];
        result_valid_o = last;
    end

    // Accumulator and sample counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/boxcar_decimator.sv
// Boxcar decimator with an Avalon-MM FIFO write master. Each group of
// 2**DECIM_LOG2 samples yields one sign-extended mean written to the FIFO.
// A result arriving while an earlier write is still stalled is discarded.
// Optional macro DECIM_DROP_CNT_EN adds a saturating drop_count output.
module boxcar_decimator
    import decim_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DECIM_LOG2 = 3
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic [FIFO_DW-1:0]       fifo_0_in_writedata,
    output logic                     fifo_0_in_write,
    input  logic                     fifo_0_in_waitrequest
`ifdef DECIM_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    logic [1:0]              rst_sync_q;
    logic                    rst_n;
    logic signed [DATA_W-1:0] result;
    logic                    res_valid;
    logic [FIFO_DW-1:0]      res_ext;
    wr_state_e               state_q, state_d;
    logic [FIFO_DW-1:0]      wdata_q, wdata_d;
`ifdef DECIM_DROP_CNT_EN
    logic                    discard;
    logic [15:0]             drop_q, drop_d;
`endif

    // Reset synchroniser: asserts immediately, releases two edges later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    decim_accum #(
        .DATA_W     (DATA_W),
        .DECIM_LOG2 (DECIM_LOG2)
    ) u_accum (
        .clk_i          (clk_clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .result_o       (result),
        .result_valid_o (res_valid)
    );

    assign res_ext = {{(FIFO_DW - DATA_W){result[DATA_W-1]}}, result};

    // Write FSM: load on result, hold while stalled, reload back-to-back.
    always_comb begin
        state_d = state_q;
        wdata_d = wdata_q;
`ifdef DECIM_DROP_CNT_EN
        discard = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (res_valid) begin
                    state_d = WRITE;
                    wdata_d = res_ext;
                end
            end
            WRITE: begin
                if (!fifo_0_in_waitrequest) begin
                    if (res_valid) begin
                        wdata_d = res_ext;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef DECIM_DROP_CNT_EN
                else if (res_valid) begin
                    discard = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and write data registers.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wdata_q <= wdata_d;
        end
    end

    assign fifo_0_in_write     = (state_q == WRITE);
    assign fifo_0_in_writedata = wdata_q;

`ifdef DECIM_DROP_CNT_EN
    // Saturating count of results discarded behind a stalled write.
    always_comb begin
        drop_d = drop_q;
        if (discard && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_boxcar_decimator.sv
// Self-checking bench for boxcar_decimator (DATA_W=16, DECIM_LOG2=2).
// A group-of-four mean model is compared against the DUT every cycle, and
// hand-computed values pin specific results and the delivered sequence.
module tb_boxcar_decimator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               waitreq = 1'b0;
    logic [31:0]        wdata;
    logic               write;
`ifdef DECIM_DROP_CNT_EN
    logic [15:0]        drop_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    boxcar_decimator #(
        .DATA_W     (16),
        .DECIM_LOG2 (2)
    ) dut (
        .clk_clk               (clk),
        .reset_reset_n         (rst_n),
        .enable                (enable),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .fifo_0_in_writedata   (wdata),
        .fifo_0_in_write       (write),
        .fifo_0_in_waitrequest (waitreq)
`ifdef DECIM_DROP_CNT_EN
        ,
        .drop_count            (drop_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floor_div4(input int s);
        int q;
        q = s / 4;
        if ((s % 4) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    // Behavioural model: groups of four samples, one pending write slot.
    int          m_grp[$];
    bit          m_wr;
    logic [31:0] m_data;
    int          m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_grp.delete();
            m_wr   = 1'b0;
            m_data = '0;
            m_drop = 0;
        end else begin
            bit got;
            int res;
            int s;
            got = 1'b0;
            res = 0;
            s   = 0;
            if (!enable) begin
                m_grp.delete();
            end else if (in_valid) begin
                m_grp.push_back(int'(in_data));
                if (m_grp.size() == 4) begin
                    foreach (m_grp[i]) s += m_grp[i];
                    res = floor_div4(s);
                    got = 1'b1;
                    m_grp.delete();
                end
            end
            if (m_wr && !waitreq) begin
                m_wr = got;
                if (got) m_data = res;
            end else if (got) begin
                if (!m_wr) begin
                    m_wr   = 1'b1;
                    m_data = res;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
        end
    end

    // Per-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        check("model_write", {31'b0, write}, {31'b0, m_wr});
        check("model_writedata", wdata, m_data);
`ifdef DECIM_DROP_CNT_EN
        check("model_drop_count", {16'b0, drop_count}, m_drop);
`endif
    end

    // Record every completed FIFO transfer as seen on the bus.
    logic [31:0] dut_deliv[$];
    always @(posedge clk) begin
        if (rst_n && write && !waitreq) dut_deliv.push_back(wdata);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int v);
        in_data  = v[15:0];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send4(input int v);
        repeat (4) send(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_deliv[7];
        exp_deliv = '{32'h2, 32'hFFFFFFFE, 32'h7FFF, 32'h6, 32'hA, 32'h4, 32'h8};

        @(negedge clk);
        enable = 1'b1;
        tick(2);
        check("reset_write", {31'b0, write}, 32'h0);
        check("reset_writedata", wdata, 32'h0);
        rst_n = 1'b1;
        tick(4);

        // 1,2,3,4 -> 2, one-cycle write
        send(1); send(2); send(3); send(4);
        check("t1_write", {31'b0, write}, 32'h1);
        check("t1_data", wdata, 32'h2);
        tick(1);
        check("t1_write_low", {31'b0, write}, 32'h0);

        // -1,-1,-2,-2 -> floor(-1.5) = -2
        send(-1); send(-1); send(-2); send(-2);
        check("t2_data", wdata, 32'hFFFFFFFE);
        tick(1);

        // full-scale positive
        send4(32767);
        check("t3_data", wdata, 32'h00007FFF);
        tick(1);

        // 5..8 -> 6, held for six cycles under waitrequest
        send(5); send(6); send(7);
        waitreq = 1'b1;
        send(8);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_write", {31'b0, write}, 32'h1);
            check("t4_hold_data", wdata, 32'h6);
            tick(1);
        end
        check("t4_last_write", {31'b0, write}, 32'h1);
        check("t4_last_data", wdata, 32'h6);
        waitreq = 1'b0;
        tick(1);
        check("t4_idle", {31'b0, write}, 32'h0);

        // stalled write, two later groups discarded
        waitreq = 1'b1;
        send4(10);
        check("t5_first", wdata, 32'hA);
        send4(20);
`ifdef DECIM_DROP_CNT_EN
        check("t5_drop1", {16'b0, drop_count}, 32'h1);
`endif
        send4(30);
`ifdef DECIM_DROP_CNT_EN
        check("t5_drop2", {16'b0, drop_count}, 32'h2);
`endif
        check("t5_keep_write", {31'b0, write}, 32'h1);
        check("t5_keep_data", wdata, 32'hA);
        waitreq = 1'b0;
        tick(1);
        check("t5_idle", {31'b0, write}, 32'h0);

        // reset after two samples flushes the partial group
        send(7); send(9);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_write", {31'b0, write}, 32'h0);
        check("t6_rst_data", wdata, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        send4(4);
        check("t6_data", wdata, 32'h4);
        tick(1);

        // enable low after three samples clears the group
        send(1); send(1); send(1);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        check("t7_no_write", {31'b0, write}, 32'h0);
        send4(8);
        check("t7_data", wdata, 32'h8);
        tick(1);

        // reset mid-transfer aborts the pending write
        waitreq = 1'b1;
        send4(3);
        check("t8_pending", {31'b0, write}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t8_abort_write", {31'b0, write}, 32'h0);
        check("t8_abort_data", wdata, 32'h0);
        tick(2);
        rst_n = 1'b1;
        waitreq = 1'b0;
        tick(4);
        check("t8_idle", {31'b0, write}, 32'h0);

        check("deliv_count", dut_deliv.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < dut_deliv.size()) check("deliv_data", dut_deliv[i], exp_deliv[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boxcar_decimator.md
BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

Interface
REQ-001 Parameter DATA_W, default 16: signed input sample width, range 8..24.
REQ-002 Parameter DECIM_LOG2, default 3: decimation factor N = 2**DECIM_LOG2, range 1..6.
REQ-003 Port clk_clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port enable, input, 1: high = decimate; low = clear the accumulation.
REQ-006 Port in_valid, input, 1: qualifies in_data for one cycle; there is no backpressure.
REQ-007 Port in_data, input, DATA_W: signed two's-complement sample.
REQ-008 Port fifo_0_in_writedata, output, 32: decimated result, sign-extended.
REQ-009 Port fifo_0_in_write, output, 1: Avalon-MM write request to the FIFO.
REQ-010 Port fifo_0_in_waitrequest, input, 1: FIFO stall.
REQ-011 Port drop_count, output, 16: present only with DECIM_DROP_CNT_EN.

Function
REQ-012 Accumulator width DATA_W+DECIM_LOG2, signed; it SHALL never overflow.
REQ-013 Sample counter 0..N-1; it SHALL advance only on the edge where in_valid=1 and enable=1, and wrap N-1 -> 0.
REQ-014 On accepting the sample at count N-1:
  - result = (acc + in_data) >>> DECIM_LOG2 (arithmetic shift, floor), sign-extended to 32 bits;
  - acc SHALL be loaded with 0 on the same edge.
REQ-015 Output FSM states and transitions:
  - IDLE: fifo_0_in_write=0.
  - WRITE: fifo_0_in_write=1.
  - IDLE -> WRITE on the edge where a result completes; writedata SHALL be loaded on that same edge (latency: 1 cycle after the Nth sample edge).
REQ-016 In WRITE, writedata and write SHALL hold stable while fifo_0_in_waitrequest=1.
REQ-017 The transfer completes on an edge with write=1 and waitrequest=0. On that edge:
  - FSM -> IDLE, unless a new result completes on the same edge;
  - if a new result completes on that edge, FSM stays in WRITE, the new result is loaded, and nothing is dropped.
REQ-018 If a result completes while in WRITE and the pending transfer does not complete on that edge:
  - the new result SHALL be discarded;
  - the pending data is kept;
  - the drop is counted (REQ-023).
REQ-019 enable=0: acc and count SHALL clear every cycle and in_valid is ignored; a pending WRITE SHALL still complete normally.
REQ-020 Accumulation SHALL continue during WRITE; the input path never stalls.

Reset
REQ-021 While reset_reset_n=0:
  - state=IDLE, fifo_0_in_write=0, fifo_0_in_writedata=0;
  - acc=0, count=0, drop_count=0.
  Reset asserted mid-transfer SHALL abort the transfer immediately.
REQ-022 Reset deassertion SHALL be synchronised internally (async assert, sync release).

Configuration
REQ-023 With macro DECIM_DROP_CNT_EN defined:
  - port drop_count exists;
  - it increments on each discard per REQ-018;
  - it saturates at 0xFFFF;
  - it is cleared only by reset.
  Without the macro, the port, counter and logic SHALL be absent, and discards are silent.

Structure
REQ-024 Shared package decim_pkg SHALL hold:
  - constant FIFO_DW=32;
  - the output FSM state typedef (IDLE, WRITE).
REQ-025 One sub-module, decim_accum, SHALL hold the accumulator and sample counter and emit result plus a result_valid pulse. The top level holds the Avalon write FSM and the drop counter.

Verification (DATA_W=16, DECIM_LOG2=2)
REQ-026 Samples 1,2,3,4 with waitrequest=0 -> write=1 for exactly one cycle, writedata=0x00000002, one cycle after the 4th sample.
REQ-027 Samples -1,-1,-2,-2 -> writedata=0xFFFFFFFE. Samples 32767 x4 -> writedata=0x00007FFF.
REQ-028 waitrequest=1 for 5 cycles after write rises -> writedata and write stable for 6 cycles, then IDLE.
REQ-029 waitrequest held high across 8 further samples (DECIM_DROP_CNT_EN) -> first result delivered, drop_count=1 then 2, no data corruption.
REQ-030 Reset pulsed after 2 samples, then samples 4,4,4,4 -> writedata=0x00000004. Separately, enable=0 after 3 samples -> no write, and the next full group is correct.
